// File: rtl/uart_receiver.sv
// uart_receiver: oversampled 8N1 UART receiver.
// Start-bit detection, mid-bit sampling of 8 data bits (LSB first) and a stop-bit
// check. Good frames update rx_data with a one-clock rx_done strobe. A frame whose
// stop bit samples low gives a single frame_error strobe, then the receiver waits
// for the line to return high, so a held-low (break) line reports only once.
module uart_receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rxd,
    input  logic       sample_tick,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_error,
    output logic [2:0] state_dbg
);

    // Output strobes: rx_done and frame_error are valid-only pulses with no
    // ready/backpressure. Each is high for exactly one clock and never together;
    // rx_data is stable from the rx_done pulse until the next good frame.

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    state_t        state, state_n;
    logic          rxd_meta, rxd_s;
    logic [TW-1:0] tick_cnt, tick_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shift_reg, shift_n;
    logic [7:0]    data_n;
    logic          done_n, ferr_n;

    assign state_dbg = state;

    // Two-flop synchronizer for the asynchronous serial line (resets to idle-high).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    // State, counters, shift register, output byte and strobes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            rx_data     <= 8'h00;
            rx_done     <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_n;
            tick_cnt    <= tick_n;
            bit_cnt     <= bit_n;
            shift_reg   <= shift_n;
            rx_data     <= data_n;
            rx_done     <= done_n;
            frame_error <= ferr_n;
        end
    end

    // Next-state logic; everything advances only on a sample_tick.
    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shift_n = shift_reg;
        data_n  = rx_data;
        done_n  = 1'b0;
        ferr_n  = 1'b0;
        if (sample_tick) begin
            case (state)
                S_IDLE: begin
                    if (!rxd_s) begin
                        state_n = S_START;
                        tick_n  = '0;
                    end
                end
                S_START: begin
                    if (tick_cnt == TICK_MID) begin
                        tick_n = '0;
                        if (!rxd_s) begin
                            state_n = S_DATA;
                            bit_n   = '0;
                        end else begin
                            // Line went back high before mid start bit: a glitch.
                            state_n = S_IDLE;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick_cnt == TICK_LAST) begin
                        shift_n = {rxd_s, shift_reg[7:1]};
                        tick_n  = '0;
                        if (bit_cnt == 3'd7) begin
                            state_n = S_STOP;
                            bit_n   = '0;
                        end else begin
                            bit_n = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_n = '0;
                        if (rxd_s) begin
                            data_n  = shift_reg;
                            done_n  = 1'b1;
                            state_n = S_IDLE;
                        end else begin
                            ferr_n  = 1'b1;
                            state_n = S_WAIT_HIGH;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rxd_s) begin
                        state_n = S_IDLE;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    tick_n  = '0;
                    bit_n   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed and randomized frames against a byte-level model.
module tb_uart_receiver;

  localparam int OS = 16;
  localparam logic [2:0] IDLE_CODE = 3'd0;
  localparam logic [2:0] WAIT_HIGH_CODE = 3'd4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       rxd = 1'b1;
  logic       sample_tick = 1'b0;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_error;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int exp_done = 0;
  int exp_ferr = 0;
  bit random_gap = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;

  uart_receiver #(.OVERSAMPLE(OS)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .rxd(rxd),
    .sample_tick(sample_tick),
    .rx_data(rx_data),
    .rx_done(rx_done),
    .frame_error(frame_error),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clock = ~clock;

  // sample_tick: periodic (every 4th clock) or a random 1-5 clock gap
  initial begin
    forever begin
      int gap;
      gap = random_gap ? int'($urandom_range(1, 5)) : 3;
      repeat (gap) @(posedge clock);
      #1 sample_tick = 1'b1;
      @(posedge clock);
      #1 sample_tick = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int c;
    c = 0;
    while (c < n) begin
      @(posedge clock);
      if (sample_tick) c++;
    end
    #2;
  endtask

  // driver: one 8N1 frame; the model records what the frame must produce
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    if (stop_ok) begin
      exp_q.push_back(b);
      exp_done++;
      last_good = b;
    end else begin
      exp_ferr++;
    end
    rxd = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_ticks(OS);
    end
    rxd = stop_ok;
    wait_ticks(OS);
  endtask

  // scoreboard: every rx_done must match the oldest expected byte
  always @(negedge clock) begin
    if (rx_done) begin
      done_cnt++;
      if (exp_q.size() == 0) chk("unexpected_rx_done", 32'd1, 32'd0);
      else chk("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      chk("pulse_overlap", {31'd0, frame_error}, 32'd0);
    end
    if (frame_error) ferr_cnt++;
  end

  task automatic report();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  initial begin
    #(90000 * 10);
    errors++;
    $display("FAIL watchdog: simulation exceeded cycle budget");
    report();
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    logic [7:0] b81;
    b81 = 8'h81;

    // reset state
    rxd = 1'b1;
    reset_n = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
    chk("reset_rx_done", {31'd0, rx_done}, 32'd0);
    chk("reset_frame_error", {31'd0, frame_error}, 32'd0);
    chk("reset_state", {29'd0, state_dbg}, {29'd0, IDLE_CODE});
    @(posedge clock);
    #2 reset_n = 1'b1;
    wait_ticks(2 * OS);

    // single frame 0xA5
    send_frame(8'hA5, 1'b1);
    rxd = 1'b1;
    wait_ticks(OS);
    chk("a5_done_count", done_cnt, exp_done);
    chk("a5_ferr_count", ferr_cnt, exp_ferr);
    chk("a5_rx_data", {24'd0, rx_data}, {24'd0, last_good});

    // back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    rxd = 1'b1;
    wait_ticks(OS);
    chk("b2b_done_count", done_cnt, exp_done);
    chk("b2b_rx_data", {24'd0, rx_data}, 32'h3C);

    // 4-tick glitch on idle line
    rxd = 1'b0;
    wait_ticks(4);
    rxd = 1'b1;
    wait_ticks(2 * OS);
    @(negedge clock);
    chk("glitch_state", {29'd0, state_dbg}, {29'd0, IDLE_CODE});
    chk("glitch_done_count", done_cnt, exp_done);
    chk("glitch_ferr_count", ferr_cnt, exp_ferr);
    chk("glitch_rx_data", {24'd0, rx_data}, {24'd0, last_good});

    // bad stop bit followed by a 40-bit break
    send_frame(8'h55, 1'b0);
    rxd = 1'b0;
    wait_ticks(40 * OS);
    @(negedge clock);
    chk("break_ferr_count", ferr_cnt, exp_ferr);
    chk("break_state", {29'd0, state_dbg}, {29'd0, WAIT_HIGH_CODE});
    rxd = 1'b1;
    wait_ticks(2 * OS);
    @(negedge clock);
    chk("break_recover_state", {29'd0, state_dbg}, {29'd0, IDLE_CODE});
    chk("break_done_count", done_cnt, exp_done);
    chk("break_ferr_final", ferr_cnt, exp_ferr);
    chk("break_rx_data", {24'd0, rx_data}, {24'd0, last_good});

    // reset in the middle of data bit 3 of 0x81
    rxd = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 3; i++) begin
      rxd = b81[i];
      wait_ticks(OS);
    end
    rxd = b81[3];
    wait_ticks(OS / 2);
    reset_n = 1'b0;
    last_good = 8'h00;
    @(negedge clock);
    chk("midreset_rx_data", {24'd0, rx_data}, 32'd0);
    chk("midreset_state", {29'd0, state_dbg}, {29'd0, IDLE_CODE});
    chk("midreset_rx_done", {31'd0, rx_done}, 32'd0);
    repeat (3) @(posedge clock);
    rxd = 1'b1;
    #2 reset_n = 1'b1;
    wait_ticks(2 * OS);
    chk("midreset_done_count", done_cnt, exp_done);
    send_frame(8'h7E, 1'b1);
    rxd = 1'b1;
    wait_ticks(OS);
    chk("after_reset_done_count", done_cnt, exp_done);
    chk("after_reset_rx_data", {24'd0, rx_data}, 32'h7E);

    // random bytes, periodic tick
    for (int i = 0; i < 6; i++) begin
      r = 8'($urandom_range(0, 255));
      send_frame(r, 1'b1);
    end
    rxd = 1'b1;
    wait_ticks(OS);
    chk("rand_periodic_done_count", done_cnt, exp_done);
    chk("rand_periodic_rx_data", {24'd0, rx_data}, {24'd0, last_good});

    // same traffic kinds with a jittery tick
    random_gap = 1'b1;
    send_frame(8'hA5, 1'b1);
    for (int i = 0; i < 8; i++) begin
      r = 8'($urandom_range(0, 255));
      send_frame(r, 1'b1);
    end
    rxd = 1'b1;
    wait_ticks(OS);
    chk("rand_gap_done_count", done_cnt, exp_done);
    chk("rand_gap_ferr_count", ferr_cnt, exp_ferr);
    chk("rand_gap_rx_data", {24'd0, rx_data}, {24'd0, last_good});
    chk("exp_queue_drained", exp_q.size(), 32'd0);

    report();
    $finish;
  end

endmodule
